stimulus_conditioner: RTL
=========================

# stimulus_conditioner

Front-end stage that produces the stimulus and tick signals the mood regulators and saturating counters consume. It synchronizes and debounces the raw external stimulus pins and detects rising edges. Rise events are held until the next mood tick, and the block generates that tick. Downstream regulators sample `stim_event` in the cycle `tick` is high, so no press shorter than a tick period is lost.

## Interface
- `N_STIM`, 7: number of stimulus channels.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change; legal range 1–15.
- `TICK_DIV`, 16: system clocks per `tick`; legal range 2–65535.

Ports:
- `clk` input 1: system clock; the only clock in the block.
- `rst_n` input 1: reset, synchronous and active-low.
- `stim_raw` input N_STIM: asynchronous raw stimulus pins.
- `tick_in` input 1: external tick source; present only when `TICK_EXT_EN` is defined.
- `stim_level` output N_STIM: debounced level per channel.
- `stim_rise` output N_STIM: one-cycle pulse per channel on a debounced 0→1 transition.
- `stim_event` output N_STIM: sticky rise flags for the current tick window.
- `tick` output 1: one-cycle pulse marking the end of a tick window.

## Operation
- Reset: all synchronizer flops, debounce counters, `stim_level`, `stim_rise`, `stim_event`, the divider count and `tick` are 0.
- Per-channel pipeline:
  - 2-flop synchronizer produces `sync`.
  - Debouncer holds a counter `cnt`, width 4:
    - if `sync == stim_level`, `cnt <= 0`;
    - else if `cnt == DEBOUNCE_CYCLES-1`, then `stim_level <= sync` and `cnt <= 0`;
    - else `cnt <= cnt+1`.
  - `stim_rise` is registered. It is high exactly in the cycle `stim_level` first reads 1 after being 0. Falling transitions update `stim_level` only; no pulse is produced.
- Event latch, per channel, evaluated each cycle:
  - if `stim_rise`, `stim_event <= 1`, regardless of `tick`;
  - else if `tick`, `stim_event <= 0`;
  - else hold.
- Consequences of the latch rule:
  - Multiple rises within one window collapse to a single flag.
  - A rise that coincides with `tick` is not counted in the closing window; it appears in the next one.
- Tick divider:
  - 16-bit count runs 0…TICK_DIV-1 and wraps.
  - `tick` is registered and is high for the cycle after count equals TICK_DIV-1, i.e. one pulse every TICK_DIV cycles.

## Timing
- Raw change sampled at edge 0:
  - `sync` is valid after edge 1.
  - `stim_level` and `stim_rise` change after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total (6 at default).
  - `stim_event` is set one edge later.
- A raw pulse whose synchronized width is shorter than DEBOUNCE_CYCLES cycles is rejected. Any mismatch-free cycle restarts the count.
- First `tick` after reset release is high during cycle TICK_DIV (0-based). Period is exactly TICK_DIV.
- Reset asserted mid-debounce or mid-window discards all partial state in that cycle. No pulse may emerge on the release edge.

## Configuration
- `TICK_EXT_EN` defined:
  - `tick_in` port exists and the internal divider is not built.
  - `tick_in` passes through a 2-flop synchronizer plus a registered rising-edge detector.
  - `tick` is high one cycle, 3 edges after the `tick_in` rise is first sampled.
  - `TICK_DIV` is ignored.
- `TICK_EXT_EN` undefined: internal divider as above; no `tick_in` port.

## Structure
- Shared package `mimosa_pkg` holds:
  - `N_STIM` default (7), shared with the regulators;
  - the debounce counter width constant (4);
  - the tick divider width constant (16).
- Sub-module `debounce_channel` contains synchronizer, debounce counter, `stim_level`/`stim_rise` registers and event latch for one channel. It takes `tick` as input and is instantiated N_STIM times by a generate loop.
- The top level holds only the divider or the external tick detector.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `stim_raw`=7'h7F → all outputs 0. After release, `stim_level`=7'h7F appears exactly 6 edges later, with a single `stim_rise`=7'h7F pulse.
- Glitch rejection: `stim_raw[2]` high for 3 cycles then low → `stim_level[2]`, `stim_rise[2]` and `stim_event[2]` stay 0. The same stimulus held 4 cycles → accepted.
- Window latch: two separated presses on ch1 inside one window → `stim_event[1]`=1 until the tick cycle, then 0 the cycle after the tick; only one event is seen by the consumer.
- Coincidence: `stim_rise[3]` in the same cycle as `tick` → `stim_event[3]`=1 the next cycle and held through the following window.
- Divider: with TICK_DIV=16, count 10 ticks → spacing exactly 16 cycles; first tick in cycle 16 after release. With `TICK_EXT_EN` and `tick_in` toggled → one tick per rise, 3-edge latency.
- Mid-operation reset: assert `rst_n`=0 while ch0 `cnt`=2 and `stim_event`=7'h05 → all cleared next edge; no `stim_rise` on the release cycle.

Source files
------------

// File: rtl/mimosa_pkg.sv
// Constants shared by the stimulus front end and the mood regulators.
package mimosa_pkg;

    localparam int N_STIM_DEFAULT = 7;
    localparam int DEB_CNT_W      = 4;
    localparam int TICK_DIV_W     = 16;

endpackage

// File: rtl/debounce_channel.sv
// One stimulus channel: 2-flop synchronizer, debouncer, rise detector and a
// sticky event flag that survives until the next tick.
module debounce_channel
    import mimosa_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stim_raw,
    input  logic tick,
    output logic stim_level,
    output logic stim_rise,
    output logic stim_event
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 event_q, event_d;

    always_comb begin
        sync1_d = stim_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;

        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A rise wins over tick so a press landing on the tick opens the next window.
        event_d = event_q;
        if (rise_q) begin
            event_d = 1'b1;
        end else if (tick) begin
            event_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            event_q <= event_d;
        end
    end

    assign stim_level = level_q;
    assign stim_rise  = rise_q;
    assign stim_event = event_q;

endmodule

// File: rtl/stimulus_conditioner.sv
// Stimulus front end: per-channel debounce/event latches plus the mood tick.
// Define TICK_EXT_EN to take the tick from the tick_in pin instead of the divider.
module stimulus_conditioner
    import mimosa_pkg::*;
#(
    parameter int N_STIM          = N_STIM_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_STIM-1:0] stim_raw,
`ifdef TICK_EXT_EN
    input  logic              tick_in,
`endif
    output logic [N_STIM-1:0] stim_level,
    output logic [N_STIM-1:0] stim_rise,
    output logic [N_STIM-1:0] stim_event,
    output logic              tick
);

    logic tick_q, tick_d;

`ifdef TICK_EXT_EN
    logic tin_s1_q, tin_s1_d;
    logic tin_s2_q, tin_s2_d;
    logic tin_prev_q, tin_prev_d;

    always_comb begin
        tin_s1_d   = tick_in;
        tin_s2_d   = tin_s1_q;
        tin_prev_d = tin_s2_q;
        tick_d     = tin_s2_q & ~tin_prev_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tin_s1_q   <= 1'b0;
            tin_s2_q   <= 1'b0;
            tin_prev_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            tin_s1_q   <= tin_s1_d;
            tin_s2_q   <= tin_s2_d;
            tin_prev_q <= tin_prev_d;
            tick_q     <= tick_d;
        end
    end
`else
    localparam logic [TICK_DIV_W-1:0] DIV_LAST = TICK_DIV_W'(TICK_DIV - 1);

    logic [TICK_DIV_W-1:0] div_q, div_d;

    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end
`endif

    for (genvar i = 0; i < N_STIM; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .stim_raw  (stim_raw[i]),
            .tick      (tick_q),
            .stim_level(stim_level[i]),
            .stim_rise (stim_rise[i]),
            .stim_event(stim_event[i])
        );
    end

    assign tick = tick_q;

endmodule
